pulse_stretcher: RTL and testbench

- Generates pulses: turns single-cycle trigger strobes into registered output pulses of programmable length.
- Guarantees an idle gap of at least GAP_CYCLES after every pulse, so a downstream edge detector always sees one rising and one falling edge per pulse.
- Sits in the util library next to the edge detector, on the driving side of strobe/level interfaces (IRQ lines, GPIO strobes, handshakes to other clock-agnostic blocks).

---
 rtl/pulse_stretcher_pkg.sv | 13 +
 rtl/sat_counter.sv | 35 +++
 rtl/pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} ps_state_e;

  // The gap counter is loaded with GAP_CYCLES-1, so at least one gap cycle must exist.
  localparam int unsigned MinGapCycles = 1;

  function automatic logic active_level(logic idle_level);
    return ~idle_level;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle trigger strobes into registered pulses of programmable length,
// followed by a guaranteed idle gap; excess triggers are queued one deep or dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          RETRIGGER  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger_i,
  input  logic [CNT_WIDTH-1:0]  length_i,
  input  logic                  clear_drop_i,
  output logic                  out,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  localparam logic ActiveLevel = active_level(IDLE_LEVEL);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);
  localparam logic [GapW-1:0] GapOne = GapW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  if (GAP_CYCLES < MinGapCycles) begin : gen_gap_check
    $error("pulse_stretcher: GAP_CYCLES must be >= 1");
  end

  ps_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] pend_len_q, pend_len_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 trig_valid;
  logic                 drop;

  // Zero-length requests are ignored everywhere: no start, reload, queue or drop.
  assign trig_valid = trigger_i && (length_i != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    drop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_valid) begin
          state_d = ACTIVE;
          cnt_d   = length_i - CntOne;
        end
      end
      ACTIVE: begin
        if (trig_valid && RETRIGGER) begin
          cnt_d = length_i - CntOne;
        end else begin
          if (trig_valid) begin
            if (pend_q) begin
              drop = 1'b1;
            end else begin
              pend_d     = 1'b1;
              pend_len_d = length_i;
            end
          end
          if (cnt_q == '0) begin
            state_d = GAP;
            gap_d   = GapLoad;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      GAP: begin
        if (trig_valid) begin
          if (pend_q) begin
            drop = 1'b1;
          end else begin
            pend_d     = 1'b1;
            pend_len_d = length_i;
          end
        end
        // A trigger arriving on the expiry cycle is already in pend_d and starts now.
        if (gap_q == '0) begin
          if (pend_d) begin
            state_d = ACTIVE;
            cnt_d   = pend_len_d - CntOne;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GapOne;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_d  = (state_d == ACTIVE) ? ActiveLevel : IDLE_LEVEL;
    done_d = (state_q == ACTIVE) && (state_d == GAP);
    busy_d = (state_d != IDLE) || pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
      out_q      <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(
    .Width(DROP_WIDTH)
  ) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (drop),
    .clr  (clear_drop_i),
    .count(drop_cnt_o)
  );

  assign out    = out_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two configurations driven in parallel, directed scenarios
// plus random traffic, all checked against a remaining-cycles reference model.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       trig = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] len = '0;

  logic       r_out, r_busy, r_done;
  logic [7:0] r_drop;
  logic       q_out, q_busy, q_done;
  logic [1:0] q_drop;

  int n_cmp = 0;
  int n_err = 0;
  int q_rises = 0;

  // Reference model: remaining active cycles, remaining gap cycles, queued length.
  int m_act[2];
  int m_gap[2];
  int m_pend[2];
  int m_drop[2];
  bit m_done[2];

  logic [7:0] exp_out, exp_done, exp_busy;
  int         base, hi, d0, ndone;
  bit         t, c;
  int         l;

  always #5 clk = ~clk;

  always @(posedge q_out) q_rises = q_rises + 1;

  // Instance 0: retriggerable, default gap.
  pulse_stretcher #(
    .CNT_WIDTH (8),
    .GAP_CYCLES(1),
    .RETRIGGER (1'b1),
    .IDLE_LEVEL(1'b0),
    .DROP_WIDTH(8)
  ) dut_r (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_i   (trig),
    .length_i    (len),
    .clear_drop_i(clr),
    .out         (r_out),
    .busy_o      (r_busy),
    .done_o      (r_done),
    .drop_cnt_o  (r_drop)
  );

  // Instance 1: queueing, two-cycle gap, narrow drop counter.
  pulse_stretcher #(
    .CNT_WIDTH (8),
    .GAP_CYCLES(2),
    .RETRIGGER (1'b0),
    .IDLE_LEVEL(1'b0),
    .DROP_WIDTH(2)
  ) dut_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_i   (trig),
    .length_i    (len),
    .clear_drop_i(clr),
    .out         (q_out),
    .busy_o      (q_busy),
    .done_o      (q_done),
    .drop_cnt_o  (q_drop)
  );

  function automatic bit retrig_of(int k);
    return k == 0;
  endfunction

  function automatic int gap_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int dmax_of(int k);
    return (k == 0) ? 255 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_gap[k] = 0; m_pend[k] = 0; m_drop[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge(bit ti, int li, bit ci);
    for (int k = 0; k < 2; k++) begin
      bit v;
      bit dropped;
      v = ti && (li != 0);
      dropped = 0;
      m_done[k] = 0;
      if (m_act[k] > 0) begin
        if (v && retrig_of(k)) begin
          m_act[k] = li;
        end else begin
          if (v) begin
            if (m_pend[k] != 0) dropped = 1;
            else m_pend[k] = li;
          end
          m_act[k] = m_act[k] - 1;
          if (m_act[k] == 0) begin
            m_gap[k] = gap_of(k);
            m_done[k] = 1;
          end
        end
      end else if (m_gap[k] > 0) begin
        if (v) begin
          if (m_pend[k] != 0) dropped = 1;
          else m_pend[k] = li;
        end
        m_gap[k] = m_gap[k] - 1;
        if (m_gap[k] == 0 && m_pend[k] != 0) begin
          m_act[k] = m_pend[k];
          m_pend[k] = 0;
        end
      end else if (v) begin
        m_act[k] = li;
      end
      if (ci) m_drop[k] = 0;
      else if (dropped && m_drop[k] < dmax_of(k)) m_drop[k] = m_drop[k] + 1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("r_out", 32'(r_out), 32'(m_act[0] > 0));
    chk("r_busy", 32'(r_busy), 32'(m_act[0] > 0 || m_gap[0] > 0 || m_pend[0] != 0));
    chk("r_done", 32'(r_done), 32'(m_done[0]));
    chk("r_drop", 32'(r_drop), 32'(m_drop[0]));
    chk("q_out", 32'(q_out), 32'(m_act[1] > 0));
    chk("q_busy", 32'(q_busy), 32'(m_act[1] > 0 || m_gap[1] > 0 || m_pend[1] != 0));
    chk("q_done", 32'(q_done), 32'(m_done[1]));
    chk("q_drop", 32'(q_drop), 32'(m_drop[1]));
  endtask

  task automatic step(bit ti, int li, bit ci);
    trig = ti;
    len  = li[7:0];
    clr  = ci;
    @(posedge clk);
    model_edge(ti, li, ci);
    #1;
    compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 compare_all();
    #9 rst_n = 1'b1;

    // Single pulse, length 3, on the two-cycle-gap instance.
    step(0, 0, 1);
    exp_out  = 8'b0000_0111;
    exp_done = 8'b0000_1000;
    exp_busy = 8'b0001_1111;
    step(1, 3, 0);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step(0, 0, 0);
      chk("single_out", 32'(q_out), 32'(exp_out[i]));
      chk("single_done", 32'(q_done), 32'(exp_done[i]));
      chk("single_busy", 32'(q_busy), 32'(exp_busy[i]));
    end
    idle(4);

    // Retrigger, length 4, triggers in cycles 0 and 2.
    exp_out  = 8'b0011_1111;
    exp_done = 8'b0100_0000;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      step(k == 0 || k == 2, 4, 0);
      if (r_done) ndone++;
      chk("retrig_out", 32'(r_out), 32'(exp_out[k]));
      chk("retrig_done", 32'(r_done), 32'(exp_done[k]));
    end
    chk("retrig_done_count", ndone, 1);
    idle(14);

    // Queueing, length 2, triggers in cycles 0, 1, 2.
    step(0, 0, 1);
    base = q_rises;
    exp_out = 8'b0011_0011;
    for (int k = 0; k < 8; k++) begin
      step(k < 3, 2, 0);
      chk("queue_out", 32'(q_out), 32'(exp_out[k]));
    end
    chk("queue_drop", 32'(q_drop), 1);
    chk("queue_rises", q_rises - base, 2);
    idle(6);

    // Zero length in IDLE and in ACTIVE.
    d0 = 32'(q_drop);
    step(1, 0, 0);
    chk("zero_idle_out", 32'(q_out), 0);
    chk("zero_idle_busy", 32'(q_busy), 0);
    hi = 0;
    step(1, 3, 0);
    if (q_out) hi++;
    step(1, 0, 0);
    if (q_out) hi++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (q_out) hi++;
    end
    chk("zero_active_len", hi, 3);
    chk("zero_drop", 32'(q_drop), d0);

    // Drop saturation and clear-over-drop.
    step(0, 0, 1);
    step(1, 8, 0);
    for (int i = 0; i < 6; i++) step(1, 8, 0);
    chk("sat_drop", 32'(q_drop), 3);
    step(1, 8, 1);
    chk("clear_wins", 32'(q_drop), 0);
    idle(30);

    // Asynchronous reset in the middle of a length-10 pulse.
    step(1, 10, 0);
    idle(3);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_q_out", 32'(q_out), 0);
    chk("rst_r_out", 32'(r_out), 0);
    chk("rst_q_busy", 32'(q_busy), 0);
    chk("rst_q_done", 32'(q_done), 0);
    compare_all();
    #2 rst_n = 1'b1;
    hi = 0;
    step(1, 10, 0);
    if (q_out) hi++;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0);
      if (q_out) hi++;
    end
    chk("post_rst_len", hi, 10);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 99) < 45);
      l = $urandom_range(0, 5);
      c = ($urandom_range(0, 99) < 4);
      step(t, l, c);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
